rv32i_regfile_accel: RTL and testbench

RV32I_REGFILE_ACCEL -- requirements
Module: rv32i_regfile_accel

---
 rtl/rv32i_regfile_accel.sv | 146 ++++++++++++++
 tb/tb_rv32i_regfile_accel.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile_accel.sv
// RV32I/RV32E register file with a memory-mapped accelerator mailbox.
// Argument, command/status and result registers live inside the architectural register space.
module rv32i_regfile_accel #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned ARG_A_IDX = 28,
    parameter int unsigned ARG_B_IDX = 29,
    parameter int unsigned CMD_IDX   = 31,
    parameter int unsigned RES_IDX   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            acc_start,
    output logic [XLEN-1:0] acc_a,
    output logic [XLEN-1:0] acc_b,
    input  logic            acc_done,
    input  logic [XLEN-1:0] acc_result,
    output logic            acc_busy
);

    localparam int unsigned AW     = $clog2(NREG);
    localparam logic [5:0]  NREG_L = 6'(NREG);
    localparam logic [4:0]  CMD_A  = 5'(CMD_IDX);
    localparam logic [4:0]  RES_A  = 5'(RES_IDX);
    localparam logic        BYP    = (BYPASS != 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state;
    logic            start_q;
    logic            busy_q;
    logic [XLEN-1:0] regs [NREG];

    logic            wr_ok;
    logic            cmd_wr;
    logic            res_load;
    logic            core_wr;
    logic            fwd_en;
    logic [XLEN-1:0] status;

    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < NREG_L);
    endfunction

    // Read mux: x0/out-of-range, status word, same-cycle forward, stored value
    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      a,
        input logic [XLEN-1:0] stored,
        input logic [XLEN-1:0] st,
        input logic            fwd,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wd
    );
        if (!in_range(a))        return '0;
        if (a == CMD_A)          return st;
        if (fwd && (a == wa))    return wd;
        return stored;
    endfunction

    assign wr_ok    = rd_we && in_range(rd_addr);
    assign cmd_wr   = wr_ok && (rd_addr == CMD_A);
    assign res_load = (state == S_BUSY) && acc_done;
    // Accelerator result wins over a colliding core write to the result register
    assign core_wr  = wr_ok && !cmd_wr && !(res_load && (rd_addr == RES_A));
    assign fwd_en   = BYP && wr_ok && !cmd_wr;

    always_comb begin
        status    = '0;
        status[1] = (state == S_BUSY);
        status[2] = (state == S_DONE);
    end

    always_comb begin
        rs1_data = read_port(rs1_addr, regs[rs1_addr[AW-1:0]], status, fwd_en, rd_addr, rd_data);
        rs2_data = read_port(rs2_addr, regs[rs2_addr[AW-1:0]], status, fwd_en, rd_addr, rd_data);
    end

    assign acc_a     = regs[AW'(ARG_A_IDX)];
    assign acc_b     = regs[AW'(ARG_B_IDX)];
    assign acc_start = start_q;
    assign acc_busy  = busy_q;

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[AW'(i)] <= '0;
            end
        end else begin
            if (core_wr) begin
                regs[rd_addr[AW-1:0]] <= rd_data;
            end
            if (res_load) begin
                regs[AW'(RES_IDX)] <= acc_result;
            end
        end
    end

    // Mailbox FSM with registered start pulse and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_wr && rd_data[0]) begin
                        state   <= S_BUSY;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (acc_done) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (cmd_wr && rd_data[0]) begin
                        state   <= S_BUSY;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (cmd_wr && rd_data[2]) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_accel.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares.
// Three instances share inputs: bypass on (NREG=32), bypass off (NREG=32), and RV32E (NREG=16).
module tb_rv32i_regfile_accel;

    localparam int K_RS1    = 0;
    localparam int K_RS2    = 1;
    localparam int K_RS1_NB = 2;
    localparam int K_RS2_NB = 3;
    localparam int K_RS1_16 = 4;
    localparam int K_RS2_16 = 5;
    localparam int K_START  = 6;
    localparam int K_BUSY   = 7;
    localparam int K_A      = 8;
    localparam int K_B      = 9;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, acc_done;
    logic [31:0] rd_data, acc_result;

    logic [31:0] rs1_p, rs2_p, a_p, b_p;
    logic        start_p, busy_p;
    logic [31:0] rs1_n, rs2_n, a_n, b_n;
    logic        start_n, busy_n;
    logic [31:0] rs1_s, rs2_s, a_s, b_s;
    logic        start_s, busy_s;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done_stim = 1'b0;

    rv32i_regfile_accel #(.BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_p), .rs2_data(rs2_p), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .acc_start(start_p), .acc_a(a_p), .acc_b(b_p), .acc_done(acc_done),
        .acc_result(acc_result), .acc_busy(busy_p));

    rv32i_regfile_accel #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_n), .rs2_data(rs2_n), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .acc_start(start_n), .acc_a(a_n), .acc_b(b_n), .acc_done(acc_done),
        .acc_result(acc_result), .acc_busy(busy_n));

    rv32i_regfile_accel #(.NREG(16), .ARG_A_IDX(12), .ARG_B_IDX(13), .CMD_IDX(15), .RES_IDX(10)) u_e (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_s), .rs2_data(rs2_s), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .acc_start(start_s), .acc_a(a_s), .acc_b(b_s), .acc_done(acc_done),
        .acc_result(acc_result), .acc_busy(busy_s));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] pick(input int k);
        case (k)
            K_RS1:    return rs1_p;
            K_RS2:    return rs2_p;
            K_RS1_NB: return rs1_n;
            K_RS2_NB: return rs2_n;
            K_RS1_16: return rs1_s;
            K_RS2_16: return rs2_s;
            K_START:  return {31'd0, start_p};
            K_BUSY:   return {31'd0, busy_p};
            K_A:      return a_p;
            K_B:      return b_p;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; stale ones count as failures
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [31:0] got;
                e = q.pop_front();
                n_cmp++;
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    got = pick(e.kind);
                    if (got !== e.val) begin
                        n_bad++;
                        $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.name, cyc, got, e.val);
                    end
                end
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd_we    = 1'b0;
        acc_done = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rd_we   = 1'b1;
        rd_addr = a;
        rd_data = d;
    endtask

    initial begin
        rst_n = 1'b0; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
        acc_done = 1'b0; acc_result = '0; rs1_addr = '0; rs2_addr = '0;

        tick(); rs1_addr = 5; rs2_addr = 0;
        expect_v(K_RS1, 0, "reset_x5"); expect_v(K_BUSY, 0, "reset_busy"); expect_v(K_START, 0, "reset_start");
        rst_n = 1'b1;

        tick(); wr(5, 32'h1234);
        expect_v(K_RS1, 32'h1234, "byp_x5"); expect_v(K_RS1_NB, 0, "nobyp_x5");
        tick();
        expect_v(K_RS1, 32'h1234, "rd_x5"); expect_v(K_RS2, 0, "rd_x0");
        expect_v(K_RS1_NB, 32'h1234, "nb_rd_x5"); expect_v(K_RS1_16, 32'h1234, "e_rd_x5");

        tick(); wr(7, 32'hA5A5); rs2_addr = 7;
        expect_v(K_RS2, 32'hA5A5, "byp_x7"); expect_v(K_RS2_NB, 0, "nobyp_x7");

        tick(); wr(28, 48); rs1_addr = 28;
        expect_v(K_RS1, 48, "byp_x28"); expect_v(K_RS1_NB, 0, "nobyp_x28"); expect_v(K_RS1_16, 0, "e_x28_oob");
        tick(); wr(29, 18); rs1_addr = 31;
        expect_v(K_RS1, 0, "cmd_idle");
        tick(); wr(31, 1);
        expect_v(K_RS1, 0, "cmd_no_byp"); expect_v(K_START, 0, "start_pre");
        tick();
        expect_v(K_START, 1, "start_pulse"); expect_v(K_A, 48, "acc_a"); expect_v(K_B, 18, "acc_b");
        expect_v(K_BUSY, 1, "busy"); expect_v(K_RS1, 2, "cmd_busy");
        tick(); wr(31, 1);
        expect_v(K_START, 0, "start_drop1"); expect_v(K_BUSY, 1, "busy_hold");
        tick(); wr(31, 1);
        expect_v(K_START, 0, "start_drop2");
        tick(); acc_done = 1'b1; acc_result = 6; rs2_addr = 10;
        expect_v(K_START, 0, "start_drop3"); expect_v(K_RS2, 0, "x10_pre");
        tick();
        expect_v(K_RS2, 6, "x10_res"); expect_v(K_RS1, 4, "cmd_done"); expect_v(K_BUSY, 0, "busy_done");
        tick(); wr(31, 4);
        expect_v(K_RS1, 4, "cmd_clr_same");
        tick();
        expect_v(K_RS1, 0, "cmd_cleared");

        tick(); acc_done = 1'b1; acc_result = 32'h77;
        tick();
        expect_v(K_RS2, 6, "done_idle_ign"); expect_v(K_RS1, 0, "cmd_idle2");

        tick(); wr(31, 1);
        tick();
        expect_v(K_START, 1, "start2");
        tick(); acc_done = 1'b1; acc_result = 9; wr(10, 3);
        expect_v(K_RS2_NB, 6, "nb_x10_old");
        tick();
        expect_v(K_RS2, 9, "res_wins"); expect_v(K_RS2_NB, 9, "nb_res_wins");
        expect_v(K_RS2_16, 3, "e_x10_core"); expect_v(K_RS1, 4, "cmd_done2");

        tick(); wr(20, 32'hFF); rs1_addr = 20;
        expect_v(K_RS1, 32'hFF, "byp_x20"); expect_v(K_RS1_16, 0, "e_x20_byp"); expect_v(K_RS1_NB, 0, "nb_x20_old");
        tick();
        expect_v(K_RS1, 32'hFF, "rd_x20"); expect_v(K_RS1_16, 0, "e_x20_ign"); expect_v(K_RS1_NB, 32'hFF, "nb_rd_x20");

        tick(); wr(31, 4);
        tick(); wr(31, 1);
        tick();
        expect_v(K_BUSY, 1, "busy3"); expect_v(K_START, 1, "start3");
        tick(); rst_n = 1'b0; rs1_addr = 5; rs2_addr = 10;
        expect_v(K_BUSY, 0, "rst_busy"); expect_v(K_START, 0, "rst_start");
        expect_v(K_RS1, 0, "rst_x5"); expect_v(K_RS2, 0, "rst_x10"); expect_v(K_RS1_NB, 0, "rst_nb_x5");
        tick(); rst_n = 1'b1; acc_done = 1'b1; acc_result = 32'h55;
        expect_v(K_RS2, 0, "post_rst_x10");
        tick(); rs1_addr = 28;
        expect_v(K_RS2, 0, "stale_done_ign"); expect_v(K_BUSY, 0, "post_rst_busy");
        expect_v(K_RS1, 0, "rst_x28"); expect_v(K_A, 0, "rst_acc_a");

        tick();
        tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
